// File: rtl/pq_cmd_sched.sv
// Round-robin command scheduler in front of an array priority queue: grants one
// push/pop/drop at a time, strobes the queue head, waits for completion and responds.
module pq_cmd_sched #(
  parameter int NREQ    = 4,
  parameter int PW      = 8,
  parameter int TW      = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0]            req_vld_i,
  input  logic [2*NREQ-1:0]          req_op_i,
  input  logic [PW*NREQ-1:0]         req_prio_i,
  input  logic [TW*NREQ-1:0]         req_id_i,
  output logic [NREQ-1:0]            req_rdy_o,
  output logic [NREQ-1:0]            rsp_vld_o,
  output logic                       rsp_err_o,
  output logic [PW-1:0]              rsp_prio_o,
  output logic [TW-1:0]              rsp_id_o,
  output logic                       pq_push_o,
  output logic                       pq_pop_o,
  output logic                       pq_drop_o,
  output logic [PW-1:0]              pq_prio_o,
  output logic [TW-1:0]              pq_id_o,
  input  logic                       pq_push_vld_i,
  input  logic                       pq_pop_vld_i,
  input  logic                       pq_drop_vld_i,
  input  logic [PW-1:0]              pq_prio_i,
  input  logic [TW-1:0]              pq_id_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int CW   = $clog2(DEPTH+1);
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMW  = $clog2(TIMEOUT+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_DROP = 2'b11;

  logic [1:0]      state_q;
  logic [1:0]      op_q;
  logic [PW-1:0]   prio_q;
  logic [TW-1:0]   id_q;
  logic [PTRW-1:0] gnt_q;
  logic [PTRW-1:0] ptr_q;
  logic [CW-1:0]   count_q;
  logic [TMW-1:0]  tmr_q;
  logic            err_q;
  logic [PW-1:0]   rsp_prio_q;
  logic [TW-1:0]   rsp_id_q;

  logic            gnt_vld;
  logic [PTRW-1:0] gnt_idx;
  logic [PTRW-1:0] cand;
  logic [1:0]      gnt_op;
  logic [PW-1:0]   gnt_prio;
  logic [TW-1:0]   gnt_id;
  logic            reject;
  logic            match;
  logic [PTRW-1:0] ptr_nxt;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PTRW'((int'(ptr_q) + i) % NREQ);
      if (!gnt_vld && req_vld_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_op   = req_op_i[2*int'(gnt_idx) +: 2];
  assign gnt_prio = req_prio_i[PW*int'(gnt_idx) +: PW];
  assign gnt_id   = req_id_i[TW*int'(gnt_idx) +: TW];
  assign ptr_nxt  = (gnt_idx == PTRW'(NREQ-1)) ? '0 : gnt_idx + PTRW'(1);

  // Misuse is answered straight from the occupancy count; the queue never sees it.
  always_comb begin
    reject = 1'b0;
    case (gnt_op)
      OP_PUSH: reject = full_o  || (gnt_id == '0);
      OP_POP:  reject = empty_o;
      OP_DROP: reject = empty_o || (gnt_id == '0);
      default: reject = 1'b1;
    endcase
  end

  always_comb begin
    match = 1'b0;
    case (op_q)
      OP_PUSH: match = pq_push_vld_i;
      OP_POP:  match = pq_pop_vld_i;
      OP_DROP: match = pq_drop_vld_i;
      default: match = 1'b0;
    endcase
  end

  // NOTE: reset is synchronous and state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      prio_q     <= '0;
      id_q       <= '0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      rsp_prio_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            op_q       <= gnt_op;
            prio_q     <= gnt_prio;
            id_q       <= gnt_id;
            gnt_q      <= gnt_idx;
            ptr_q      <= ptr_nxt;
            err_q      <= reject;
            rsp_prio_q <= '0;
            rsp_id_q   <= '0;
            state_q    <= reject ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmr_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (match) begin
            state_q <= S_RESP;
            err_q   <= 1'b0;
            if (op_q == OP_PUSH) begin
              count_q <= count_q + CW'(1);
            end else begin
              count_q <= count_q - CW'(1);
            end
            if (op_q == OP_POP) begin
              rsp_prio_q <= pq_prio_i;
              rsp_id_q   <= pq_id_i;
            end
          end else if (tmr_q == TMW'(TIMEOUT-1)) begin
            state_q <= S_RESP;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMW'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_rdy_o  = (state_q == S_IDLE && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
  assign rsp_vld_o  = (state_q == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
  assign rsp_err_o  = (state_q == S_RESP) && err_q;
  assign rsp_prio_o = (state_q == S_RESP) ? rsp_prio_q : '0;
  assign rsp_id_o   = (state_q == S_RESP) ? rsp_id_q : '0;

  assign pq_push_o = (state_q == S_ISSUE) && (op_q == OP_PUSH);
  assign pq_pop_o  = (state_q == S_ISSUE) && (op_q == OP_POP);
  assign pq_drop_o = (state_q == S_ISSUE) && (op_q == OP_DROP);
  assign pq_prio_o = (state_q == S_ISSUE || state_q == S_WAIT) ? prio_q : '0;
  assign pq_id_o   = (state_q == S_ISSUE || state_q == S_WAIT) ? id_q : '0;

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_pq_cmd_sched.sv
// Directed bench for pq_cmd_sched; the bench itself plays the requesters and the queue.
module tb_pq_cmd_sched;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  req_vld_i;
  logic [7:0]  req_op_i;
  logic [31:0] req_prio_i;
  logic [15:0] req_id_i;
  logic [3:0]  req_rdy_o;
  logic [3:0]  rsp_vld_o;
  logic        rsp_err_o;
  logic [7:0]  rsp_prio_o;
  logic [3:0]  rsp_id_o;
  logic        pq_push_o, pq_pop_o, pq_drop_o;
  logic [7:0]  pq_prio_o;
  logic [3:0]  pq_id_o;
  logic        pq_push_vld_i, pq_pop_vld_i, pq_drop_vld_i;
  logic [7:0]  pq_prio_i;
  logic [3:0]  pq_id_i;
  logic [3:0]  count_o;
  logic        full_o, empty_o;

  int checks = 0;
  int errors = 0;

  pq_cmd_sched #(.NREQ(4), .PW(8), .TW(4), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_op_i(req_op_i), .req_prio_i(req_prio_i), .req_id_i(req_id_i),
    .req_rdy_o(req_rdy_o), .rsp_vld_o(rsp_vld_o), .rsp_err_o(rsp_err_o),
    .rsp_prio_o(rsp_prio_o), .rsp_id_o(rsp_id_o),
    .pq_push_o(pq_push_o), .pq_pop_o(pq_pop_o), .pq_drop_o(pq_drop_o),
    .pq_prio_o(pq_prio_o), .pq_id_o(pq_id_o),
    .pq_push_vld_i(pq_push_vld_i), .pq_pop_vld_i(pq_pop_vld_i), .pq_drop_vld_i(pq_drop_vld_i),
    .pq_prio_i(pq_prio_i), .pq_id_i(pq_id_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
  endtask

  // One full command from requester r; the bench answers as the queue when respond is set.
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [7:0] prio,
                        input logic [3:0] id, input bit respond, input logic [7:0] q_prio,
                        input logic [3:0] q_id, input bit exp_issue, input bit exp_err,
                        input int exp_lat, input logic [7:0] exp_prio, input logic [3:0] exp_id,
                        input bit chk_id, input string tag);
    int n;
    int lat;
    int strobe_cycles;
    bit issued;
    bit responded;
    logic [2:0] strobe_seen;
    logic [2:0] exp_strobe;
    logic [3:0] issued_id;
    logic [3:0] oh;
    n = 0; lat = 0; strobe_cycles = 0; issued = 1'b0; responded = 1'b0;
    strobe_seen = 3'b000; issued_id = 4'h0;
    oh = 4'b0001 << r;
    case (op)
      2'b01:   exp_strobe = 3'b100;
      2'b10:   exp_strobe = 3'b010;
      2'b11:   exp_strobe = 3'b001;
      default: exp_strobe = 3'b000;
    endcase
    if (!exp_issue) exp_strobe = 3'b000;
    req_op_i[2*r +: 2]   = op;
    req_prio_i[8*r +: 8] = prio;
    req_id_i[4*r +: 4]   = id;
    req_vld_i[r]         = 1'b1;
    #1;
    while (req_rdy_o === 4'b0000 && n < 50) begin
      cyc();
      n++;
    end
    check({tag, "_rdy"}, 32'(req_rdy_o), 32'(oh));
    cyc();
    req_vld_i[r] = 1'b0;
    lat = 1;
    while (rsp_vld_o === 4'b0000 && lat < 40) begin
      if ({pq_push_o, pq_pop_o, pq_drop_o} !== 3'b000) begin
        strobe_seen = strobe_seen | {pq_push_o, pq_pop_o, pq_drop_o};
        strobe_cycles++;
        issued_id = pq_id_o;
        issued = 1'b1;
        cyc();
      end else if (issued && respond && !responded) begin
        pq_prio_i = q_prio;
        pq_id_i   = q_id;
        pq_push_vld_i = (op == 2'b01);
        pq_pop_vld_i  = (op == 2'b10);
        pq_drop_vld_i = (op == 2'b11);
        responded = 1'b1;
        cyc();
        pq_push_vld_i = 1'b0;
        pq_pop_vld_i  = 1'b0;
        pq_drop_vld_i = 1'b0;
        pq_prio_i = 8'h00;
        pq_id_i   = 4'h0;
      end else begin
        cyc();
      end
      lat++;
    end
    check({tag, "_rsp_vld"}, 32'(rsp_vld_o), 32'(oh));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(rsp_err_o), 32'(exp_err));
    check({tag, "_rsp_prio"}, 32'(rsp_prio_o), 32'(exp_prio));
    if (chk_id) check({tag, "_rsp_id"}, 32'(rsp_id_o), 32'(exp_id));
    check({tag, "_strobe"}, 32'(strobe_seen), 32'(exp_strobe));
    check({tag, "_strobe_cycles"}, 32'(strobe_cycles), exp_issue ? 32'd1 : 32'd0);
    if (exp_issue) check({tag, "_pq_id"}, 32'(issued_id), 32'(id));
    cyc();
  endtask

  initial begin
    int n;
    rst_i = 1'b0;
    req_vld_i = '0; req_op_i = '0; req_prio_i = '0; req_id_i = '0;
    pq_push_vld_i = 1'b0; pq_pop_vld_i = 1'b0; pq_drop_vld_i = 1'b0;
    pq_prio_i = '0; pq_id_i = '0;

    // Reset values
    do_reset();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_rdy", 32'(req_rdy_o), 32'd0);
    check("rst_rsp", 32'(rsp_vld_o), 32'd0);
    check("rst_strobes", 32'({pq_push_o, pq_pop_o, pq_drop_o}), 32'd0);
    check("rst_pq_id", 32'(pq_id_o), 32'd0);

    // Single push from requester 0
    do_cmd(0, 2'b01, 8'd5, 4'd3, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b1, "push1");
    check("push1_count", 32'(count_o), 32'd1);
    check("push1_empty", 32'(empty_o), 32'd0);

    // Round-robin: all four push continuously, queue completes every push at once
    do_reset();
    req_vld_i = 4'hF;
    req_op_i  = 8'b01_01_01_01;
    req_id_i  = 16'h4321;
    req_prio_i = 32'h04030201;
    pq_push_vld_i = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_rdy_o === 4'b0000 && n < 10) begin
        cyc();
        n++;
      end
      check("rr_grant", 32'(req_rdy_o), 32'd1 << (k % 4));
      cyc();
    end
    req_vld_i = 4'h0;
    cyc(); cyc(); cyc();
    pq_push_vld_i = 1'b0;
    cyc();
    check("rr_count", 32'(count_o), 32'd5);

    // Fill to DEPTH, then overflow push is rejected
    do_cmd(1, 2'b01, 8'd6, 4'd5, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b1, "fill6");
    do_cmd(1, 2'b01, 8'd7, 4'd6, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b1, "fill7");
    do_cmd(1, 2'b01, 8'd8, 4'd7, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b1, "fill8");
    check("full_count", 32'(count_o), 32'd8);
    check("full_flag", 32'(full_o), 32'd1);
    do_cmd(2, 2'b01, 8'd1, 4'd9, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1, 8'd0, 4'd0, 1'b1, "ovf");
    check("ovf_count", 32'(count_o), 32'd8);
    check("ovf_full", 32'(full_o), 32'd1);

    // Pop returns the queue's head values
    do_cmd(3, 2'b10, 8'd0, 4'd0, 1'b1, 8'd9, 4'd2, 1'b1, 1'b0, 3, 8'd9, 4'd2, 1'b1, "pop");
    check("pop_count", 32'(count_o), 32'd7);
    check("pop_full", 32'(full_o), 32'd0);

    // Drop of an absent id times out; unrelated completions are ignored meanwhile
    pq_push_vld_i = 1'b1;
    pq_pop_vld_i  = 1'b1;
    do_cmd(0, 2'b11, 8'd0, 4'd7, 1'b0, 8'd0, 4'd0, 1'b1, 1'b1, 18, 8'd0, 4'd0, 1'b1, "drop_miss");
    pq_push_vld_i = 1'b0;
    pq_pop_vld_i  = 1'b0;
    check("drop_miss_count", 32'(count_o), 32'd7);
    do_cmd(1, 2'b11, 8'd0, 4'd4, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b0, "drop_hit");
    check("drop_hit_count", 32'(count_o), 32'd6);

    // Misuse on an empty queue and illegal commands
    do_reset();
    do_cmd(2, 2'b10, 8'd0, 4'd0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1, 8'd0, 4'd0, 1'b1, "pop_empty");
    do_cmd(3, 2'b11, 8'd0, 4'd5, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1, 8'd0, 4'd0, 1'b1, "drop_empty");
    do_cmd(0, 2'b00, 8'd3, 4'd5, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1, 8'd0, 4'd0, 1'b1, "op00");
    do_cmd(1, 2'b01, 8'd3, 4'd0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1, 8'd0, 4'd0, 1'b1, "push_id0");
    check("misuse_count", 32'(count_o), 32'd0);

    // Reset while a push is waiting for the queue
    do_cmd(0, 2'b01, 8'd2, 4'd9, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 3, 8'd0, 4'd0, 1'b1, "pre_rst");
    check("pre_rst_count", 32'(count_o), 32'd1);
    req_op_i[5:4]   = 2'b01;
    req_prio_i[23:16] = 8'd4;
    req_id_i[11:8]  = 4'd3;
    req_vld_i[2]    = 1'b1;
    #1;
    n = 0;
    while (req_rdy_o === 4'b0000 && n < 10) begin
      cyc();
      n++;
    end
    check("mid_rdy", 32'(req_rdy_o), 32'b0100);
    cyc();
    req_vld_i[2] = 1'b0;
    check("mid_issue", 32'(pq_push_o), 32'd1);
    cyc();
    check("mid_wait_id", 32'(pq_id_o), 32'd3);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    check("mid_rsp", 32'(rsp_vld_o), 32'd0);
    check("mid_count", 32'(count_o), 32'd0);
    check("mid_empty", 32'(empty_o), 32'd1);
    check("mid_pq_id", 32'(pq_id_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("post_rst_rsp", 32'({rsp_vld_o, req_rdy_o, pq_push_o}), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
